rename_ckpt_map: RTL and testbench
==================================

Name: rename_ckpt_map

Overview:
- Parametrised register-rename core: map table, free list, architectural map and a checkpoint ring.
- Renames up to rwd instructions per cycle and returns physical tags one cycle later.
- Restores state in one cycle on branch mispredict (checkpoint) or full flush (architectural map).
- Sits between decode and dispatch; commit drives the architectural map and register release.

Parameters:
- rwd, 2, rename slots per cycle.
- cwd, 2, commit slots per cycle.
- lrnum, 32, logical registers; lreg 0 is hardwired to preg 0.
- prnum, 64, physical registers; preg 0 is never allocated or freed.
- brsz, 8, checkpoint slots (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  rwd  rename request per slot, in program order
- req_br  in  rwd  slot needs a checkpoint (branch/jump)
- req_rd/req_rs1/req_rs2  in  rwd×clog2(lrnum)  logical registers
- req_ready  out  rwd  slot accepted this cycle (combinational)
- rsp_valid  out  rwd  registered result valid
- rsp_prd/rsp_old_prd/rsp_prs1/rsp_prs2  out  rwd×clog2(prnum)  physical tags
- rsp_ckpt  out  rwd×clog2(brsz)  checkpoint id (valid when slot had req_br)
- com_valid  in  cwd  commit slot valid
- com_lrd  in  cwd×clog2(lrnum)  committed logical destination
- com_prd  in  cwd×clog2(prnum)  committed new preg
- com_old_prd  in  cwd×clog2(prnum)  preg to free
- res_valid  in  1  branch resolved
- res_ckpt  in  clog2(brsz)  resolved checkpoint id
- res_mis  in  1  mispredicted
- flush  in  1  full pipeline flush
- busy  out  1  RECOVER state

Behaviour:
- Reset state: mt=0, amt=0, fl=all ones except bit 0, ckpt ring head=tail=0 with count 0, state NORMAL, rsp_valid=0. All other outputs are 0.

State machine:
- NORMAL → RECOVER on flush or (res_valid & res_mis).
- RECOVER lasts exactly 1 cycle, then → NORMAL.
- A flush or mispredict arriving while in RECOVER is applied again and stays in RECOVER.

Acceptance (combinational):
- Accept the longest prefix of valid slots. For slot i, all of the following must hold:
  - all earlier slots accepted;
  - free pregs ≥ count of accepted slots with rd≠0;
  - free checkpoints ≥ count of accepted req_br;
  - state NORMAL, and no flush or mispredict this cycle.
- Allocation takes the lowest-index free pregs in slot order. rd=0 allocates nothing and sets prd=0.

Mapping:
- rs1/rs2/old_prd read mt with intra-group bypass from earlier accepted slots.
- lreg 0 always reads 0.
- Results are registered and appear at the next edge; latency is 1.

Checkpoints:
- An accepted req_br takes slot tail and advances tail. The snapshot of mt and fl includes the effects of that slot and all earlier slots in the group.
- Commit frees are also OR'd into every stored fl snapshot.

Commit:
- Each valid slot writes amt[com_lrd]=com_prd, applied in slot order, and sets fl[com_old_prd].
- com_old_prd=0 and com_lrd=0 are ignored.

Resolution:
- Correct: mark the ckpt done; head advances past done entries, at most brsz per cycle.
- Mispredict on k:
  - mt ← snap_mt[k];
  - fl ← snap_fl[k] | this cycle's commit frees;
  - tail ← k, dropping k and all younger checkpoints.
- Flush (priority over mispredict):
  - mt ← amt after this cycle's commits;
  - fl ← every preg not referenced by that amt, excluding bit 0;
  - ckpt ring emptied.
- Responses already registered are not killed; downstream discards them by ckpt age.
- Checkpoint ring full → a branch slot stalls at its position; earlier slots still proceed.

Test Plan:
- After reset, 2 slots (rd=1, rd=2, rs1=1 in slot 1) → next cycle prd=1,2, slot 1 prs1=1, old_prd=0,0.
- Allocate 63 pregs, then request rd=5 → req_ready=0. Commit com_old_prd=7 → next cycle accept, prd=7.
- Branch at ckpt 0, rename rd=3 → prd=X. Mispredict ckpt 0 → busy 1 cycle, then rs1=3 maps to pre-X value and X is reallocated first.
- 8 branches outstanding, 9th req_br stalls. Resolve ckpt 0 correct → 9th accepted, rsp_ckpt=0.
- Flush with commit in same cycle of lrd=4→prd=9 → mt[4]=9, fl excludes every amt-referenced preg and 0.
- Commit com_old_prd=0 or com_lrd=0 → no change to fl or amt.

Source files
------------

// File: rtl/rename_ckpt_map.sv
// Register-rename core: speculative map table, free list, architectural map and a ring of
// branch checkpoints. Mispredicts and flushes restore state in one cycle.
module rename_ckpt_map #(
    parameter int unsigned rwd   = 2,
    parameter int unsigned cwd   = 2,
    parameter int unsigned lrnum = 32,
    parameter int unsigned prnum = 64,
    parameter int unsigned brsz  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [rwd-1:0]                       req_valid,
    input  logic [rwd-1:0]                       req_br,
    input  logic [rwd-1:0][$clog2(lrnum)-1:0]    req_rd,
    input  logic [rwd-1:0][$clog2(lrnum)-1:0]    req_rs1,
    input  logic [rwd-1:0][$clog2(lrnum)-1:0]    req_rs2,
    output logic [rwd-1:0]                       req_ready,
    output logic [rwd-1:0]                       rsp_valid,
    output logic [rwd-1:0][$clog2(prnum)-1:0]    rsp_prd,
    output logic [rwd-1:0][$clog2(prnum)-1:0]    rsp_old_prd,
    output logic [rwd-1:0][$clog2(prnum)-1:0]    rsp_prs1,
    output logic [rwd-1:0][$clog2(prnum)-1:0]    rsp_prs2,
    output logic [rwd-1:0][$clog2(brsz)-1:0]     rsp_ckpt,
    input  logic [cwd-1:0]                       com_valid,
    input  logic [cwd-1:0][$clog2(lrnum)-1:0]    com_lrd,
    input  logic [cwd-1:0][$clog2(prnum)-1:0]    com_prd,
    input  logic [cwd-1:0][$clog2(prnum)-1:0]    com_old_prd,
    input  logic                                 res_valid,
    input  logic [$clog2(brsz)-1:0]              res_ckpt,
    input  logic                                 res_mis,
    input  logic                                 flush,
    output logic                                 busy
);

    localparam int unsigned pw  = $clog2(prnum);
    localparam int unsigned cw  = $clog2(brsz);
    localparam int unsigned fcw = $clog2(prnum + 1);
    localparam int unsigned kcw = cw + 1;

    localparam logic [0:0] StNormal  = 1'b0;
    localparam logic [0:0] StRecover = 1'b1;

    typedef logic [lrnum-1:0][pw-1:0] map_t;

    logic [0:0]       state_q, state_d;
    map_t             mt_q, mt_d, amt_q, amt_d, mt_w;
    logic [prnum-1:0] fl_q, fl_d, fl_w, com_free, amt_ref;
    map_t             snap_mt_q [brsz];
    map_t             snap_mt_d [brsz];
    logic [prnum-1:0] snap_fl_q [brsz];
    logic [prnum-1:0] snap_fl_d [brsz];
    logic [brsz-1:0]  done_q, done_d;
    logic [cw-1:0]    head_q, head_d, tail_q, tail_d, slot;
    logic [kcw-1:0]   cnt_q, cnt_d, ck_free, n_br;
    logic [fcw-1:0]   free_cnt, n_alloc;
    logic [pw-1:0]    new_p;
    logic             go, need_p, mis;

    logic [rwd-1:0]          rsp_valid_q, rsp_valid_d;
    logic [rwd-1:0][pw-1:0]  rsp_prd_q, rsp_prd_d, rsp_old_prd_q, rsp_old_prd_d;
    logic [rwd-1:0][pw-1:0]  rsp_prs1_q, rsp_prs1_d, rsp_prs2_q, rsp_prs2_d;
    logic [rwd-1:0][cw-1:0]  rsp_ckpt_q, rsp_ckpt_d;

    always_comb begin
        mis = res_valid && res_mis;

        // Commit: architectural map updates in slot order, plus the pregs released this cycle.
        com_free = '0;
        amt_d    = amt_q;
        for (int c = 0; c < cwd; c++) begin
            if (com_valid[c] && com_lrd[c] != '0) begin
                amt_d[com_lrd[c]] = com_prd[c];
                if (com_old_prd[c] != '0) begin
                    com_free[com_old_prd[c]] = 1'b1;
                end
            end
        end

        amt_ref = '0;
        for (int l = 0; l < lrnum; l++) begin
            amt_ref[amt_d[l]] = 1'b1;
        end

        free_cnt = '0;
        for (int p = 1; p < prnum; p++) begin
            free_cnt = free_cnt + fcw'(fl_q[p]);
        end
        ck_free = kcw'(brsz) - cnt_q;

        mt_w    = mt_q;
        fl_w    = fl_q;
        done_d  = done_q;
        n_alloc = '0;
        n_br    = '0;
        slot    = '0;
        new_p   = '0;
        need_p  = 1'b0;
        for (int j = 0; j < brsz; j++) begin
            snap_mt_d[j] = snap_mt_q[j];
            snap_fl_d[j] = snap_fl_q[j] | com_free;
        end

        req_ready     = '0;
        rsp_prd_d     = '0;
        rsp_old_prd_d = '0;
        rsp_prs1_d    = '0;
        rsp_prs2_d    = '0;
        rsp_ckpt_d    = '0;
        go            = (state_q == StNormal) && !flush && !mis;

        // mt_w/fl_w carry the effects of earlier slots, giving the intra-group bypass.
        for (int i = 0; i < rwd; i++) begin
            need_p = req_rd[i] != '0;
            new_p  = '0;
            for (int p = int'(prnum) - 1; p >= 1; p--) begin
                if (fl_w[p]) new_p = pw'(p);
            end
            if (go && req_valid[i] && (n_alloc + fcw'(need_p) <= free_cnt)
                && (n_br + kcw'(req_br[i]) <= ck_free)) begin
                req_ready[i]     = 1'b1;
                rsp_prs1_d[i]    = mt_w[req_rs1[i]];
                rsp_prs2_d[i]    = mt_w[req_rs2[i]];
                rsp_old_prd_d[i] = mt_w[req_rd[i]];
                if (need_p) begin
                    rsp_prd_d[i]      = new_p;
                    fl_w[new_p]       = 1'b0;
                    mt_w[req_rd[i]]   = new_p;
                    n_alloc           = n_alloc + fcw'(1);
                end
                if (req_br[i]) begin
                    slot            = tail_q + cw'(n_br);
                    rsp_ckpt_d[i]   = slot;
                    snap_mt_d[slot] = mt_w;
                    snap_fl_d[slot] = fl_w | com_free;
                    done_d[slot]    = 1'b0;
                    n_br            = n_br + kcw'(1);
                end
            end else begin
                go = 1'b0;
            end
        end
        rsp_valid_d = req_ready;

        head_d = head_q;
        if (flush) begin
            mt_d    = amt_d;
            fl_d    = ~amt_ref;
            fl_d[0] = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            cnt_d   = '0;
            done_d  = '0;
        end else if (mis) begin
            mt_d   = snap_mt_q[res_ckpt];
            fl_d   = snap_fl_q[res_ckpt] | com_free;
            tail_d = res_ckpt;
            cnt_d  = {1'b0, res_ckpt - head_q};
        end else begin
            mt_d   = mt_w;
            fl_d   = fl_w | com_free;
            tail_d = tail_q + cw'(n_br);
            cnt_d  = cnt_q + n_br;
            if (res_valid) done_d[res_ckpt] = 1'b1;
        end

        // Retire resolved checkpoints from the head; out-of-order resolutions wait here.
        for (int j = 0; j < brsz; j++) begin
            if (cnt_d != '0 && done_d[head_d]) begin
                done_d[head_d] = 1'b0;
                head_d         = head_d + cw'(1);
                cnt_d          = cnt_d - kcw'(1);
            end
        end

        state_d = (flush || mis) ? StRecover : StNormal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StNormal;
            mt_q          <= '0;
            amt_q         <= '0;
            fl_q          <= {{(prnum-1){1'b1}}, 1'b0};
            done_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_prd_q     <= '0;
            rsp_old_prd_q <= '0;
            rsp_prs1_q    <= '0;
            rsp_prs2_q    <= '0;
            rsp_ckpt_q    <= '0;
        end else begin
            state_q       <= state_d;
            mt_q          <= mt_d;
            amt_q         <= amt_d;
            fl_q          <= fl_d;
            done_q        <= done_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_prd_q     <= rsp_prd_d;
            rsp_old_prd_q <= rsp_old_prd_d;
            rsp_prs1_q    <= rsp_prs1_d;
            rsp_prs2_q    <= rsp_prs2_d;
            rsp_ckpt_q    <= rsp_ckpt_d;
        end
    end

    // Snapshot storage is only meaningful for live ring entries, so it needs no reset.
    always_ff @(posedge clk) begin
        snap_mt_q <= snap_mt_d;
        snap_fl_q <= snap_fl_d;
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_prd     = rsp_prd_q;
    assign rsp_old_prd = rsp_old_prd_q;
    assign rsp_prs1    = rsp_prs1_q;
    assign rsp_prs2    = rsp_prs2_q;
    assign rsp_ckpt    = rsp_ckpt_q;
    assign busy        = (state_q == StRecover);

endmodule

// File: tb/tb_rename_ckpt_map.sv
// Directed bench for rename_ckpt_map: a table of rename groups from reset plus hand-written
// sequences for free-list exhaustion, mispredict recovery, checkpoint-ring full and flush.
module tb_rename_ckpt_map;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_br, req_ready, rsp_valid;
    logic [1:0][4:0] req_rd, req_rs1, req_rs2;
    logic [1:0][5:0] rsp_prd, rsp_old_prd, rsp_prs1, rsp_prs2;
    logic [1:0][2:0] rsp_ckpt;
    logic [1:0]      com_valid;
    logic [1:0][4:0] com_lrd;
    logic [1:0][5:0] com_prd, com_old_prd;
    logic            res_valid, res_mis, flush, busy;
    logic [2:0]      res_ckpt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rename_ckpt_map dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_br(req_br), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_prd(rsp_prd), .rsp_old_prd(rsp_old_prd),
        .rsp_prs1(rsp_prs1), .rsp_prs2(rsp_prs2), .rsp_ckpt(rsp_ckpt),
        .com_valid(com_valid), .com_lrd(com_lrd), .com_prd(com_prd), .com_old_prd(com_old_prd),
        .res_valid(res_valid), .res_ckpt(res_ckpt), .res_mis(res_mis),
        .flush(flush), .busy(busy)
    );

    typedef struct packed {
        logic [1:0] valid;
        logic [4:0] rd0, rd1, rs10, rs11, rs20, rs21;
        logic [1:0] ready;
        logic [5:0] prd0, prd1, old0, old1, p10, p11, p20, p21;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_slot(input string name, input int s, input int prd, input int old,
                            input int p1, input int p2);
        chk({name, " prd"}, int'(rsp_prd[s]), prd);
        chk({name, " old_prd"}, int'(rsp_old_prd[s]), old);
        chk({name, " prs1"}, int'(rsp_prs1[s]), p1);
        chk({name, " prs2"}, int'(rsp_prs2[s]), p2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0; req_br = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        com_valid = '0; com_lrd = '0; com_prd = '0; com_old_prd = '0;
        res_valid = 1'b0; res_mis = 1'b0; res_ckpt = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        //         valid  rd0   rd1   rs10  rs11  rs20  rs21   ready prd0 prd1 old0 old1 p10  p11  p20  p21
        vt[0] = '{2'b11, 5'd1, 5'd2, 5'd0, 5'd1, 5'd0, 5'd0,  2'b11, 6'd1, 6'd2, 6'd0, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0};
        vt[1] = '{2'b11, 5'd1, 5'd0, 5'd2, 5'd1, 5'd1, 5'd3,  2'b11, 6'd3, 6'd0, 6'd1, 6'd0, 6'd2, 6'd3, 6'd1, 6'd0};
        vt[2] = '{2'b01, 5'd2, 5'd5, 5'd1, 5'd0, 5'd2, 5'd0,  2'b01, 6'd4, 6'd0, 6'd2, 6'd0, 6'd3, 6'd0, 6'd2, 6'd0};
        vt[3] = '{2'b10, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0,  2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        vt[4] = '{2'b11, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd0,  2'b11, 6'd5, 6'd6, 6'd4, 6'd5, 6'd4, 6'd5, 6'd4, 6'd0};
        vt[5] = '{2'b11, 5'd0, 5'd0, 5'd1, 5'd2, 5'd0, 5'd31, 2'b11, 6'd0, 6'd0, 6'd0, 6'd0, 6'd3, 6'd6, 6'd0, 6'd0};

        // Reset state
        do_reset();
        #1;
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset rsp_prd", int'(rsp_prd), 0);
        chk("reset req_ready", int'(req_ready), 0);

        // Table of rename groups applied back-to-back from reset
        for (int k = 0; k < 6; k++) begin
            req_valid  = vt[k].valid;
            req_rd[0]  = vt[k].rd0;  req_rd[1]  = vt[k].rd1;
            req_rs1[0] = vt[k].rs10; req_rs1[1] = vt[k].rs11;
            req_rs2[0] = vt[k].rs20; req_rs2[1] = vt[k].rs21;
            #1;
            chk($sformatf("vec%0d req_ready", k), int'(req_ready), int'(vt[k].ready));
            tick();
            chk($sformatf("vec%0d rsp_valid", k), int'(rsp_valid), int'(vt[k].ready));
            if (vt[k].ready[0])
                chk_slot($sformatf("vec%0d s0", k), 0, vt[k].prd0, vt[k].old0, vt[k].p10, vt[k].p20);
            if (vt[k].ready[1])
                chk_slot($sformatf("vec%0d s1", k), 1, vt[k].prd1, vt[k].old1, vt[k].p11, vt[k].p21);
        end

        // Free-list exhaustion and release by commit
        do_reset();
        for (int g = 0; g < 31; g++) begin
            req_valid = 2'b11; req_rd[0] = 5'd1; req_rd[1] = 5'd1;
            tick();
        end
        chk("fl last pair prd0", int'(rsp_prd[0]), 61);
        chk("fl last pair prd1", int'(rsp_prd[1]), 62);
        req_rd[1] = 5'd2;
        #1;
        chk("fl one left ready", int'(req_ready), 1);
        tick();
        chk("fl one left rsp_valid", int'(rsp_valid), 1);
        chk("fl one left prd", int'(rsp_prd[0]), 63);
        req_valid = 2'b01; req_rd[0] = 5'd5;
        #1;
        chk("fl empty ready", int'(req_ready), 0);
        req_rd[0] = 5'd0;
        #1;
        chk("fl empty rd0 ready", int'(req_ready), 1);
        tick();
        chk("fl empty rd0 prd", int'(rsp_prd[0]), 0);
        req_rd[0] = 5'd5;
        com_valid = 2'b11;
        com_lrd[0] = 5'd3; com_prd[0] = 6'd9;  com_old_prd[0] = 6'd0;
        com_lrd[1] = 5'd0; com_prd[1] = 6'd10; com_old_prd[1] = 6'd0;
        tick();
        com_valid = '0;
        #1;
        chk("fl old_prd0 no free", int'(req_ready), 0);
        com_valid = 2'b01;
        com_lrd[0] = 5'd1; com_prd[0] = 6'd63; com_old_prd[0] = 6'd7;
        #1;
        chk("fl commit same cycle ready", int'(req_ready), 0);
        tick();
        com_valid = '0;
        #1;
        chk("fl after commit ready", int'(req_ready), 1);
        tick();
        chk("fl realloc prd", int'(rsp_prd[0]), 7);
        chk("fl realloc old_prd", int'(rsp_old_prd[0]), 0);

        // Mispredict recovery
        do_reset();
        req_valid = 2'b11; req_br = 2'b10; req_rd[0] = 5'd3; req_rd[1] = 5'd0;
        tick();
        chk("mis pre prd", int'(rsp_prd[0]), 1);
        chk("mis br ckpt", int'(rsp_ckpt[1]), 0);
        req_valid = 2'b01; req_br = 2'b00; req_rd[0] = 5'd3;
        tick();
        chk("mis X prd", int'(rsp_prd[0]), 2);
        chk("mis X old_prd", int'(rsp_old_prd[0]), 1);
        req_rd[0] = 5'd4;
        res_valid = 1'b1; res_mis = 1'b1; res_ckpt = 3'd0;
        #1;
        chk("mis cycle ready", int'(req_ready), 0);
        tick();
        res_valid = 1'b0; res_mis = 1'b0;
        chk("mis busy", int'(busy), 1);
        #1;
        chk("mis recover ready", int'(req_ready), 0);
        tick();
        chk("mis busy cleared", int'(busy), 0);
        req_rs1[0] = 5'd3; req_br = 2'b01;
        #1;
        chk("mis after ready", int'(req_ready), 1);
        tick();
        chk("mis restored prs1", int'(rsp_prs1[0]), 1);
        chk("mis X reused", int'(rsp_prd[0]), 2);
        chk("mis tail rollback", int'(rsp_ckpt[0]), 0);

        // Checkpoint ring full
        do_reset();
        for (int g = 0; g < 4; g++) begin
            req_valid = 2'b11; req_br = 2'b11; req_rd = '0;
            #1;
            chk($sformatf("ck fill%0d ready", g), int'(req_ready), 3);
            tick();
            chk($sformatf("ck fill%0d id0", g), int'(rsp_ckpt[0]), 2 * g);
            chk($sformatf("ck fill%0d id1", g), int'(rsp_ckpt[1]), 2 * g + 1);
        end
        req_br = 2'b10; req_rd[0] = 5'd1;
        #1;
        chk("ck full partial ready", int'(req_ready), 1);
        tick();
        chk("ck full partial prd", int'(rsp_prd[0]), 1);
        req_valid = 2'b01; req_br = 2'b01; req_rd = '0;
        res_valid = 1'b1; res_mis = 1'b0; res_ckpt = 3'd0;
        #1;
        chk("ck full stall", int'(req_ready), 0);
        tick();
        res_valid = 1'b0;
        #1;
        chk("ck freed ready", int'(req_ready), 1);
        tick();
        chk("ck ninth id", int'(rsp_ckpt[0]), 0);
        req_valid = 2'b11; req_br = 2'b11;
        res_valid = 1'b1; res_ckpt = 3'd2;
        #1;
        chk("ck ooo stall a", int'(req_ready), 0);
        tick();
        res_ckpt = 3'd1;
        #1;
        chk("ck ooo stall b", int'(req_ready), 0);
        tick();
        res_valid = 1'b0;
        #1;
        chk("ck two freed ready", int'(req_ready), 3);
        tick();
        chk("ck two freed id0", int'(rsp_ckpt[0]), 1);
        chk("ck two freed id1", int'(rsp_ckpt[1]), 2);

        // Flush with a same-cycle commit
        do_reset();
        req_valid = 2'b11; req_rd[0] = 5'd4; req_rd[1] = 5'd5;
        tick();
        req_valid = 2'b01;
        tick();
        chk("fx spec prd", int'(rsp_prd[0]), 3);
        req_valid = '0;
        com_valid = 2'b11;
        com_lrd[0] = 5'd5; com_prd[0] = 6'd2;  com_old_prd[0] = 6'd0;
        com_lrd[1] = 5'd0; com_prd[1] = 6'd12; com_old_prd[1] = 6'd0;
        tick();
        flush = 1'b1;
        com_valid = 2'b01;
        com_lrd[0] = 5'd4; com_prd[0] = 6'd9; com_old_prd[0] = 6'd0;
        req_valid = 2'b01; req_rd[0] = 5'd1;
        #1;
        chk("fx flush ready", int'(req_ready), 0);
        tick();
        flush = 1'b0; com_valid = '0;
        chk("fx busy", int'(busy), 1);
        #1;
        chk("fx recover ready", int'(req_ready), 0);
        tick();
        req_valid = 2'b11;
        req_rd[0] = 5'd6;  req_rd[1] = 5'd7;
        req_rs1[0] = 5'd4; req_rs1[1] = 5'd0;
        req_rs2[0] = 5'd5; req_rs2[1] = 5'd0;
        #1;
        chk("fx after ready", int'(req_ready), 3);
        tick();
        chk_slot("fx s0", 0, 1, 0, 9, 2);
        chk_slot("fx s1", 1, 3, 0, 0, 0);
        req_rs1 = '0; req_rs2 = '0;
        for (int g = 0; g < 4; g++) begin
            int e0, e1;
            case (g)
                0: begin e0 = 4;  e1 = 5;  end
                1: begin e0 = 6;  e1 = 7;  end
                2: begin e0 = 8;  e1 = 10; end
                default: begin e0 = 11; e1 = 12; end
            endcase
            req_rd[0] = 5'd8; req_rd[1] = 5'd9;
            tick();
            chk($sformatf("fx alloc%0d prd0", g), int'(rsp_prd[0]), e0);
            chk($sformatf("fx alloc%0d prd1", g), int'(rsp_prd[1]), e1);
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
